// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory-access stage.
//   mem_state_e  - stage FSM encoding (MemIdle, MemBusy)
//   Be*          - byte-lane mask constants for word / low half / high half
//   misaligned() - alignment test used when MEM_MISALIGN_CHK_EN is defined
package mem_access_pkg;

    typedef enum logic {
        MemIdle = 1'b0,
        MemBusy = 1'b1
    } mem_state_e;

    localparam logic [3:0] BeWord = 4'b1111;
    localparam logic [3:0] BeHlo  = 4'b0011;
    localparam logic [3:0] BeHhi  = 4'b1100;

    // Word access needs addr[1:0] == 0, halfword access needs addr[0] == 0.
    function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] addr_lo);
        logic is_half;
        is_half = (mask == BeHlo) || (mask == BeHhi);
        return ((mask == BeWord) && (addr_lo != 2'b00)) || (is_half && addr_lo[0]);
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: combinational load-data aligner.
//   rdata   in  32  raw bus word
//   rden    in  4   load byte-lane mask (selects the field)
//   sext    in  1   1 = sign-extend the field, 0 = zero-extend
//   aligned out 32  right-justified, extended load value
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  rden,
    input  logic        sext,
    output logic [31:0] aligned
);

    always_comb begin
        aligned = rdata;
        case (rden)
            BeWord:  aligned = rdata;
            BeHlo:   aligned = {{16{sext & rdata[15]}}, rdata[15:0]};
            BeHhi:   aligned = {{16{sext & rdata[31]}}, rdata[31:16]};
            4'b0001: aligned = {{24{sext & rdata[7]}},  rdata[7:0]};
            4'b0010: aligned = {{24{sext & rdata[15]}}, rdata[15:8]};
            4'b0100: aligned = {{24{sext & rdata[23]}}, rdata[23:16]};
            4'b1000: aligned = {{24{sext & rdata[31]}}, rdata[31:24]};
            default: aligned = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage following execute.
// Non-memory ops pass straight to the writeback record with one cycle of latency. Memory ops
// drive a single-outstanding req/ack bus, stall upstream while pending, and align load data.
//   clk, rst (sync, active-high)
//   EX_*        registered execute outputs (rd, valid, result, address, masks, sext, store data)
//   dbus_*      req/ack data bus (word address, byte enables, store data, ack + read data)
//   MEM_stall   combinational, high while BUSY
//   MEM_rd/_rd_vld/_x_rd  writeback record
//   MEM_err     one-cycle pulse on bus timeout (WAIT_MAX cycles, 0 disables)
//   MEM_misalign one-cycle pulse on a rejected misaligned access
// Build option: define MEM_MISALIGN_CHK_EN to reject misaligned word/halfword accesses;
// otherwise MEM_misalign stays 0 and addr[1:0] is simply dropped.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  EX_rd,
    input  logic        EX_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [31:0] EX_MEM_addr,
    input  logic [3:0]  EX_MEM_rden,
    input  logic        EX_MEM_rden_SEXT,
    input  logic [3:0]  EX_MEM_wren,
    input  logic [31:0] EX_MEM_wrdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        MEM_stall,
    output logic [4:0]  MEM_rd,
    output logic        MEM_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic        MEM_err,
    output logic        MEM_misalign
);

    localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax     = '1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      cap_rd_q, cap_rd_d;
    logic            cap_vld_q, cap_vld_d;
    logic [3:0]      cap_rden_q, cap_rden_d;
    logic            cap_sext_q, cap_sext_d;

    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            vld_q, vld_d;
    logic [31:0]     x_q, x_d;
    logic            err_q, err_d;
    logic            mis_q, mis_d;

    logic            mem_op;
    logic [3:0]      op_mask;
    logic            reject;
    logic [31:0]     load_val;

    assign mem_op  = (EX_MEM_rden != 4'b0000) || (EX_MEM_wren != 4'b0000);
    // rden wins when both masks are set, so an illegal op is treated as a load.
    assign op_mask = (EX_MEM_rden != 4'b0000) ? EX_MEM_rden : EX_MEM_wren;

`ifdef MEM_MISALIGN_CHK_EN
    assign reject = misaligned(op_mask, EX_MEM_addr[1:0]);
`else
    assign reject = 1'b0;
`endif

    mem_access_load_align u_load_align (
        .rdata   (dbus_rdata),
        .rden    (cap_rden_q),
        .sext    (cap_sext_q),
        .aligned (load_val)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_rd_d   = cap_rd_q;
        cap_vld_d  = cap_vld_q;
        cap_rden_d = cap_rden_q;
        cap_sext_d = cap_sext_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        vld_d      = vld_q;
        x_d        = x_q;
        err_d      = 1'b0;
        mis_d      = 1'b0;

        unique case (state_q)
            MemIdle: begin
                if (!mem_op) begin
                    rd_d  = EX_rd;
                    x_d   = EX_x_rd;
                    vld_d = EX_rd_vld;
                end else if (reject) begin
                    mis_d = 1'b1;
                    vld_d = 1'b0;
                end else begin
                    cap_rd_d   = EX_rd;
                    cap_vld_d  = EX_rd_vld;
                    cap_rden_d = EX_MEM_rden;
                    cap_sext_d = EX_MEM_rden_SEXT;
                    req_d      = 1'b1;
                    we_d       = (EX_MEM_rden == 4'b0000);
                    be_d       = op_mask;
                    addr_d     = EX_MEM_addr & 32'hFFFF_FFFC;
                    wdata_d    = EX_MEM_wrdata;
                    vld_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = MemBusy;
                end
            end
            MemBusy: begin
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = MemIdle;
                    if (!we_q) begin
                        x_d   = load_val;
                        rd_d  = cap_rd_q;
                        vld_d = cap_vld_q;
                    end else begin
                        vld_d = 1'b0;
                    end
                end else if ((WAIT_MAX != 0) && (cnt_q == TimeoutCnt)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    state_d = MemIdle;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = MemIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MemIdle;
            cnt_q      <= '0;
            cap_rd_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_rden_q <= '0;
            cap_sext_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            vld_q      <= 1'b0;
            x_q        <= '0;
            err_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_rd_q   <= cap_rd_d;
            cap_vld_q  <= cap_vld_d;
            cap_rden_q <= cap_rden_d;
            cap_sext_q <= cap_sext_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            vld_q      <= vld_d;
            x_q        <= x_d;
            err_q      <= err_d;
            mis_q      <= mis_d;
        end
    end

    assign MEM_stall    = (state_q == MemBusy);
    assign dbus_req     = req_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = addr_q;
    assign dbus_be      = be_q;
    assign dbus_wdata   = wdata_q;
    assign MEM_rd       = rd_q;
    assign MEM_rd_vld   = vld_q;
    assign MEM_x_rd     = x_q;
    assign MEM_err      = err_q;
    assign MEM_misalign = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (WAIT_MAX = 4).
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [4:0]  EX_rd;
    logic        EX_rd_vld;
    logic [31:0] EX_x_rd;
    logic [31:0] EX_MEM_addr;
    logic [3:0]  EX_MEM_rden;
    logic        EX_MEM_rden_SEXT;
    logic [3:0]  EX_MEM_wren;
    logic [31:0] EX_MEM_wrdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        MEM_stall;
    logic [4:0]  MEM_rd;
    logic        MEM_rd_vld;
    logic [31:0] MEM_x_rd;
    logic        MEM_err;
    logic        MEM_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    // First-request-cycle snapshot of the bus, taken by run_op.
    logic [31:0] f_addr;
    logic [3:0]  f_be;
    logic        f_we;
    logic [31:0] f_wdata;
    int          stall_n, req_n, err_n;

    mem_access #(.WAIT_MAX(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .EX_rd            (EX_rd),
        .EX_rd_vld        (EX_rd_vld),
        .EX_x_rd          (EX_x_rd),
        .EX_MEM_addr      (EX_MEM_addr),
        .EX_MEM_rden      (EX_MEM_rden),
        .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
        .EX_MEM_wren      (EX_MEM_wren),
        .EX_MEM_wrdata    (EX_MEM_wrdata),
        .dbus_req         (dbus_req),
        .dbus_we          (dbus_we),
        .dbus_addr        (dbus_addr),
        .dbus_be          (dbus_be),
        .dbus_wdata       (dbus_wdata),
        .dbus_ack         (dbus_ack),
        .dbus_rdata       (dbus_rdata),
        .MEM_stall        (MEM_stall),
        .MEM_rd           (MEM_rd),
        .MEM_rd_vld       (MEM_rd_vld),
        .MEM_x_rd         (MEM_x_rd),
        .MEM_err          (MEM_err),
        .MEM_misalign     (MEM_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] rd, input logic vld, input logic [31:0] addr,
                          input logic [3:0] rden, input logic sext, input logic [3:0] wren,
                          input logic [31:0] wdata);
        EX_rd            = rd;
        EX_rd_vld        = vld;
        EX_MEM_addr      = addr;
        EX_MEM_rden      = rden;
        EX_MEM_rden_SEXT = sext;
        EX_MEM_wren      = wren;
        EX_MEM_wrdata    = wdata;
    endtask

    task automatic clear_op();
        EX_MEM_rden = 4'b0000;
        EX_MEM_wren = 4'b0000;
        EX_rd_vld   = 1'b0;
    endtask

    // Capture the presented op, then ack on the ack_at-th stalled cycle (0 = never).
    task automatic run_op(input int ack_at, input logic [31:0] data);
        stall_n = 0;
        req_n   = 0;
        err_n   = 0;
        step();
        clear_op();
        f_addr  = dbus_addr;
        f_be    = dbus_be;
        f_we    = dbus_we;
        f_wdata = dbus_wdata;
        for (int i = 0; i < 32; i++) begin
            if (dbus_req) req_n++;
            if (MEM_err) err_n++;
            if (!MEM_stall) break;
            stall_n++;
            if (stall_n == ack_at) begin
                dbus_ack   = 1'b1;
                dbus_rdata = data;
            end
            step();
            dbus_ack = 1'b0;
        end
        if (MEM_stall) check("op_bound", {31'b0, MEM_stall}, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        EX_x_rd    = '0;
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        set_op(5'd0, 1'b0, 32'h0, 4'b0, 1'b0, 4'b0, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_req",   {31'b0, dbus_req},     32'h0);
        check("rst_stall", {31'b0, MEM_stall},    32'h0);
        check("rst_vld",   {31'b0, MEM_rd_vld},   32'h0);
        check("rst_err",   {31'b0, MEM_err},      32'h0);
        check("rst_mis",   {31'b0, MEM_misalign}, 32'h0);
        check("rst_x",     MEM_x_rd,              32'h0);

        // Non-memory passthrough, two in a row
        set_op(5'd5, 1'b1, 32'h0, 4'b0, 1'b0, 4'b0, 32'h0);
        EX_x_rd = 32'h0000_1234;
        step();
        check("add_rd",    {27'b0, MEM_rd},    32'd5);
        check("add_x",     MEM_x_rd,           32'h0000_1234);
        check("add_vld",   {31'b0, MEM_rd_vld}, 32'h1);
        check("add_stall", {31'b0, MEM_stall}, 32'h0);
        set_op(5'd7, 1'b0, 32'h0, 4'b0, 1'b0, 4'b0, 32'h0);
        EX_x_rd = 32'h0000_ABCD;
        step();
        check("add2_rd",  {27'b0, MEM_rd},     32'd7);
        check("add2_x",   MEM_x_rd,            32'h0000_ABCD);
        check("add2_vld", {31'b0, MEM_rd_vld}, 32'h0);

        // LB signed, ack on the 3rd request cycle
        set_op(5'd9, 1'b1, 32'h0000_0103, 4'b1000, 1'b1, 4'b0, 32'h0);
        run_op(3, 32'h8012_3456);
        check("lb_addr",  f_addr,              32'h0000_0100);
        check("lb_be",    {28'b0, f_be},       32'h8);
        check("lb_we",    {31'b0, f_we},       32'h0);
        check("lb_stall", stall_n,             32'd3);
        check("lb_req",   {31'b0, dbus_req},   32'h0);
        check("lb_x",     MEM_x_rd,            32'hFFFF_FF80);
        check("lb_rd",    {27'b0, MEM_rd},     32'd9);
        check("lb_vld",   {31'b0, MEM_rd_vld}, 32'h1);

        // LHU high half, ack on first request cycle; captured on first IDLE cycle after ack
        set_op(5'd10, 1'b1, 32'h0000_0202, 4'b1100, 1'b0, 4'b0, 32'h0);
        run_op(1, 32'hBEEF_0000);
        check("lhu_addr",  f_addr,      32'h0000_0200);
        check("lhu_be",    {28'b0, f_be}, 32'hC);
        check("lhu_stall", stall_n,     32'd1);
        check("lhu_x",     MEM_x_rd,    32'h0000_BEEF);

        // LH signed low half
        set_op(5'd11, 1'b1, 32'h0000_0204, 4'b0011, 1'b1, 4'b0, 32'h0);
        run_op(1, 32'h1234_8001);
        check("lh_x", MEM_x_rd, 32'hFFFF_8001);

        // LBU lane 1, zero-extended
        set_op(5'd12, 1'b1, 32'h0000_0301, 4'b0010, 1'b0, 4'b0, 32'h0);
        run_op(2, 32'h0000_AB00);
        check("lbu1_x", MEM_x_rd, 32'h0000_00AB);

        // LB signed lane 2, positive byte
        set_op(5'd13, 1'b1, 32'h0000_0302, 4'b0100, 1'b1, 4'b0, 32'h0);
        run_op(1, 32'h0071_0000);
        check("lb2_x", MEM_x_rd, 32'h0000_0071);

        // LW
        set_op(5'd14, 1'b1, 32'h0000_0308, 4'b1111, 1'b1, 4'b0, 32'h0);
        run_op(1, 32'hDEAD_BEEF);
        check("lw_x",   MEM_x_rd,        32'hDEAD_BEEF);
        check("lw_rd",  {27'b0, MEM_rd}, 32'd14);

        // SW: no writeback
        set_op(5'd3, 1'b1, 32'h0000_0300, 4'b0000, 1'b0, 4'b1111, 32'hCAFE_F00D);
        run_op(2, 32'h0);
        check("sw_we",    {31'b0, f_we},       32'h1);
        check("sw_be",    {28'b0, f_be},       32'hF);
        check("sw_wdata", f_wdata,             32'hCAFE_F00D);
        check("sw_vld",   {31'b0, MEM_rd_vld}, 32'h0);
        check("sw_x",     MEM_x_rd,            32'hDEAD_BEEF);

        // Both masks set: treated as a load with rden
        set_op(5'd15, 1'b1, 32'h0000_0400, 4'b0001, 1'b0, 4'b1111, 32'h0);
        run_op(1, 32'h0000_00C3);
        check("ill_we", {31'b0, f_we},  32'h0);
        check("ill_be", {28'b0, f_be},  32'h1);
        check("ill_x",  MEM_x_rd,       32'h0000_00C3);

        // Timeout: req high 4 cycles, one err pulse, spurious ack ignored
        set_op(5'd16, 1'b1, 32'h0000_0500, 4'b1111, 1'b0, 4'b0, 32'h0);
        run_op(0, 32'h0);
        check("to_req_n", req_n,               32'd4);
        check("to_err_n", err_n,               32'd1);
        check("to_vld",   {31'b0, MEM_rd_vld}, 32'h0);
        check("to_req",   {31'b0, dbus_req},   32'h0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h5555_5555;
        step();
        dbus_ack = 1'b0;
        check("to_err_once", {31'b0, MEM_err},   32'h0);
        check("spur_stall",  {31'b0, MEM_stall}, 32'h0);
        check("spur_req",    {31'b0, dbus_req},  32'h0);

        // Reset during BUSY, late ack, then a normal op
        set_op(5'd17, 1'b1, 32'h0000_0600, 4'b1111, 1'b0, 4'b0, 32'h0);
        step();
        clear_op();
        check("rb_req_pre", {31'b0, dbus_req}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rb_req",   {31'b0, dbus_req},  32'h0);
        check("rb_stall", {31'b0, MEM_stall}, 32'h0);
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h7777_7777;
        step();
        dbus_ack = 1'b0;
        check("rb_late_vld", {31'b0, MEM_rd_vld}, 32'h0);
        set_op(5'd18, 1'b1, 32'h0000_0700, 4'b1111, 1'b0, 4'b0, 32'h0);
        run_op(1, 32'h1122_3344);
        check("rb_next_x",   MEM_x_rd,            32'h1122_3344);
        check("rb_next_vld", {31'b0, MEM_rd_vld}, 32'h1);

        // Misaligned LW at 0x102
        set_op(5'd19, 1'b1, 32'h0000_0102, 4'b1111, 1'b0, 4'b0, 32'h0);
`ifdef MEM_MISALIGN_CHK_EN
        step();
        clear_op();
        check("mis_req",   {31'b0, dbus_req},     32'h0);
        check("mis_pulse", {31'b0, MEM_misalign}, 32'h1);
        check("mis_vld",   {31'b0, MEM_rd_vld},   32'h0);
        check("mis_stall", {31'b0, MEM_stall},    32'h0);
        step();
        check("mis_once",  {31'b0, MEM_misalign}, 32'h0);
`else
        run_op(1, 32'h0BAD_F00D);
        check("mis_addr",  f_addr,                32'h0000_0100);
        check("mis_x",     MEM_x_rd,              32'h0BAD_F00D);
        check("mis_pulse", {31'b0, MEM_misalign}, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute stage. It consumes the registered execute outputs: destination register, result value, memory address, byte-lane read/write masks, sign-extend flag and store data. It drives a single-outstanding req/ack data bus and aligns and sign-extends load data. It stalls upstream while a bus transaction is pending and presents the writeback record (rd, valid, value) to the register file.

## Interface
- WAIT_MAX, 15: bus timeout in cycles while waiting for ack; 0 disables the timeout.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- EX_rd  in  5  destination register
- EX_rd_vld  in  1  destination write valid
- EX_x_rd  in  32  ALU/CSR/link result
- EX_MEM_addr  in  32  byte address
- EX_MEM_rden  in  4  load byte-lane mask
- EX_MEM_rden_SEXT  in  1  sign-extend load result
- EX_MEM_wren  in  4  store byte-lane mask
- EX_MEM_wrdata  in  32  lane-replicated store data
- dbus_req  out  1  request; held until ack or abort
- dbus_we  out  1  1 = store
- dbus_addr  out  32  word address, {addr[31:2],2'b00}
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  store data
- dbus_ack  in  1  completion, single cycle
- dbus_rdata  in  32  load data, valid with ack
- MEM_stall  out  1  upstream must hold its outputs
- MEM_rd  out  5  writeback register
- MEM_rd_vld  out  1  writeback valid
- MEM_x_rd  out  32  writeback value
- MEM_err  out  1  one-cycle pulse on bus timeout
- MEM_misalign  out  1  one-cycle pulse (macro only)

## Operation
- FSM states: IDLE, BUSY.
- **IDLE, non-memory op** (rden == 0 and wren == 0):
  - MEM_rd <= EX_rd, MEM_x_rd <= EX_x_rd, MEM_rd_vld <= EX_rd_vld.
  - Stay in IDLE.
- **IDLE, memory op:**
  - Capture rd, rd_vld, rden, SEXT and addr[1:0].
  - dbus_req <= 1; dbus_we <= (rden == 0); dbus_be <= the nonzero mask; load dbus_addr and dbus_wdata.
  - MEM_rd_vld <= 0; clear the wait counter; go to BUSY.
- **rden and wren both nonzero** (illegal): rden wins; the op is treated as a load.
- **BUSY, ack high:**
  - dbus_req <= 0; return to IDLE.
  - Load: MEM_x_rd <= aligned data; MEM_rd <= captured rd; MEM_rd_vld <= captured rd_vld.
  - Store: MEM_rd_vld <= 0.
- **BUSY, no ack:** the counter increments.
  - If WAIT_MAX != 0 and the counter reaches WAIT_MAX - 1: dbus_req <= 0, MEM_err <= 1 for one cycle, MEM_rd_vld <= 0, go to IDLE.
- **Load alignment:**
  - rden 1111: word.
  - 0011: rdata[15:0]; 1100: rdata[31:16].
  - 0001, 0010, 0100, 1000: byte lanes 0–3.
  - SEXT = 1 replicates the top bit of the selected field; SEXT = 0 zero-extends.
- Inputs present while in BUSY are ignored.
- dbus_ack seen in IDLE is ignored.

## Timing
- Reset: state IDLE; all outputs 0, including dbus_req, MEM_rd_vld, MEM_err and MEM_misalign.
- Reset during BUSY: dbus_req drops on the next edge and the pending op is discarded. A late ack is ignored.
- MEM_stall is combinational: (state == BUSY).
- Non-memory ops: 1-cycle latency, full throughput.
- Memory ops:
  - Capture edge T; dbus_req high from T+1.
  - Ack sampled at edge T+k gives the writeback output at T+k with dbus_req low.
  - MEM_stall is high for cycles T+1 through the ack cycle inclusive.
  - Minimum occupancy is 2 cycles (ack on first req cycle).
- Back-to-back memory ops: the next op is captured on the first IDLE cycle after ack. There are no bus gaps beyond that one cycle.
- The counter is $clog2(WAIT_MAX+1) bits wide and saturates; it does not wrap.

## Configuration
- Macro: MEM_MISALIGN_CHK_EN.
- **Defined:** in IDLE, these accesses are rejected:
  - word mask with addr[1:0] != 0
  - halfword mask with addr[0] == 1
  - Result: no bus request, MEM_misalign <= 1 for one cycle, MEM_rd_vld <= 0, stay in IDLE, no stall.
- **Undefined:** MEM_misalign is tied to 0; the access proceeds with addr[1:0] dropped and the masks used as given.

## Structure
- defines.v gains:
  - MEM state encodings (MEM_IDLE, MEM_BUSY)
  - byte-mask constants (BE_WORD = 4'b1111, BE_HLO = 4'b0011, BE_HHI = 4'b1100)
- One combinational sub-module, load_align.
  - Inputs: rdata, rden, SEXT. Output: the 32-bit aligned value.
  - It is reused by any future load path.

## Test plan
- ADD passthrough: EX_rd = 5, EX_x_rd = 0x1234, rd_vld = 1 -> next cycle MEM_rd = 5, MEM_x_rd = 0x1234, vld = 1, no stall.
- LB signed: addr 0x103, rden 1000, SEXT = 1, ack after 3 cycles with rdata 0x80xxxxxx -> dbus_addr 0x100, be 1000, MEM_x_rd 0xFFFFFF80, stall for exactly 3 cycles.
- LHU: addr 0x202, rden 1100, rdata 0xBEEF0000 -> MEM_x_rd 0x0000BEEF. SW: wren 1111 -> dbus_we = 1, be 1111, MEM_rd_vld = 0.
- Timeout, WAIT_MAX = 4, ack never asserted -> req high for 4 cycles, MEM_err pulses once, back to IDLE; a later spurious ack is ignored.
- Reset asserted during BUSY -> dbus_req 0 and stall 0 on the next cycle; the next op is captured normally.
- MEM_MISALIGN_CHK_EN defined, LW at 0x102 -> no req, MEM_misalign pulse, MEM_rd_vld = 0.
